// File: rtl/mul_exec.sv
// Issue-queued iterative multiplier: a small FIFO feeds a radix-2 shift-add engine
// that returns the low 32 bits of each product, one at a time, in issue order.
module mul_exec #(
    parameter int QDEPTH = 4,
    parameter int ITER   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exception_sig,
    input  logic        mret_sig,
    input  logic [56:0] issue_in,
    output logic [7:0]  rf_raddr1,
    output logic [7:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        MUL_result_valid,
    output logic [7:0]  MUL_result_dest,
    output logic [31:0] MUL_result_data,
    output logic [31:0] MUL_result_PC,
    output logic        mul_busy,
    output logic        q_overflow
);

    localparam int PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNTW = $clog2(ITER + 1);
    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic            flush;
    logic [55:0]     fifo_mem [QDEPTH];
    logic [PTRW:0]   wr_ptr_reg;
    logic [PTRW:0]   rd_ptr_reg;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [55:0]     head;

    logic [1:0]      state_reg, state_next;
    logic [31:0]     acc_reg, acc_next;
    logic [31:0]     mcand_reg, mcand_next;
    logic [31:0]     mplier_reg, mplier_next;
    logic [31:0]     pc_reg, pc_next;
    logic [7:0]      rd_reg, rd_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic            overflow_reg;

    logic [7:0]      op_tag   [2];
    logic [31:0]     op_rdata [2];
    logic [31:0]     op_val   [2];

    assign flush      = reset | exception_sig | mret_sig;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTRW] != rd_ptr_reg[PTRW]) &&
                        (wr_ptr_reg[PTRW-1:0] == rd_ptr_reg[PTRW-1:0]);
    assign head       = fifo_mem[rd_ptr_reg[PTRW-1:0]];

    // A full queue still accepts when the head leaves on the same edge.
    assign pop  = !fifo_empty && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign push = issue_in[56] && (!fifo_full || pop);
    assign drop = issue_in[56] && fifo_full && !pop;

    assign rf_raddr1   = head[15:8];
    assign rf_raddr2   = head[7:0];
    assign op_tag[0]   = head[15:8];
    assign op_tag[1]   = head[7:0];
    assign op_rdata[0] = rf_rdata1;
    assign op_rdata[1] = rf_rdata2;

    // Physical tag 0 is the hard-wired zero register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign op_val[gi] = (op_tag[gi] == 8'd0) ? 32'd0 : op_rdata[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_mem[wr_ptr_reg[PTRW-1:0]] <= issue_in[55:0];
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        pc_next     = pc_reg;
        rd_next     = rd_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            S_BUSY: begin
                if (mplier_reg[0]) begin
                    acc_next = acc_reg + mcand_reg;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CNTW'(1);
                if (cnt_reg == LAST_ITER) begin
                    state_next = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                if (pop) begin
                    state_next  = S_BUSY;
                    acc_next    = 32'd0;
                    cnt_next    = '0;
                    mcand_next  = op_val[0];
                    mplier_next = op_val[1];
                    pc_next     = head[55:24];
                    rd_next     = head[23:16];
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            acc_reg      <= 32'd0;
            mcand_reg    <= 32'd0;
            mplier_reg   <= 32'd0;
            pc_reg       <= 32'd0;
            rd_reg       <= 8'd0;
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            pc_reg     <= pc_next;
            rd_reg     <= rd_next;
            cnt_reg    <= cnt_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign MUL_result_valid = (state_reg == S_DONE);
    assign MUL_result_dest  = MUL_result_valid ? rd_reg  : 8'd0;
    assign MUL_result_data  = MUL_result_valid ? acc_reg : 32'd0;
    assign MUL_result_PC    = MUL_result_valid ? pc_reg  : 32'd0;
    assign mul_busy         = (state_reg != S_IDLE) || !fifo_empty;
    assign q_overflow       = overflow_reg;

endmodule

// File: tb/tb_mul_exec.sv
// Self-checking bench for mul_exec: table-driven products plus hand-written
// back-to-back, full-queue, overflow and flush sequences, checked via a scoreboard.
module tb_mul_exec;

    localparam int ITER   = 32;
    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        exception_sig;
    logic        mret_sig;
    logic [56:0] issue_in;
    logic [7:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        MUL_result_valid;
    logic [7:0]  MUL_result_dest;
    logic [31:0] MUL_result_data;
    logic [31:0] MUL_result_PC;
    logic        mul_busy;
    logic        q_overflow;

    always #5 clk = ~clk;

    mul_exec #(.QDEPTH(QDEPTH), .ITER(ITER)) dut (
        .clk              (clk),
        .reset            (reset),
        .exception_sig    (exception_sig),
        .mret_sig         (mret_sig),
        .issue_in         (issue_in),
        .rf_raddr1        (rf_raddr1),
        .rf_raddr2        (rf_raddr2),
        .rf_rdata1        (rf_rdata1),
        .rf_rdata2        (rf_rdata2),
        .MUL_result_valid (MUL_result_valid),
        .MUL_result_dest  (MUL_result_dest),
        .MUL_result_data  (MUL_result_data),
        .MUL_result_PC    (MUL_result_PC),
        .mul_busy         (mul_busy),
        .q_overflow       (q_overflow)
    );

    logic [31:0] regfile [256];
    assign rf_rdata1 = regfile[rf_raddr1];
    assign rf_rdata2 = regfile[rf_raddr2];

    typedef struct {
        logic [7:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  t1;
        logic [7:0]  t2;
        logic [7:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] prod;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   last_exp   = 0;
    int   last_pulse = 0;
    bit   mon_en     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor: every pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (MUL_result_valid === 1'b1) begin
                last_pulse = cyc;
                check("busy_during_done", 64'(mul_busy), 64'd1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got dest 0x%0h data 0x%0h at cycle %0d, required no pulse",
                             MUL_result_dest, MUL_result_data, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("result_data", 64'(MUL_result_data), 64'(mon_e.data));
                    check("result_dest", 64'(MUL_result_dest), 64'(mon_e.dest));
                    check("result_pc",   64'(MUL_result_PC),   64'(mon_e.pc));
                    check("result_cycle", 64'(cyc), 64'(mon_e.cyc));
                    $display("result dest=0x%0h data=0x%08h pc=0x%08h cycle=%0d",
                             MUL_result_dest, MUL_result_data, MUL_result_PC, cyc);
                end
            end else begin
                check("idle_outputs_zero",
                      64'({24'd0, MUL_result_dest} | MUL_result_data | MUL_result_PC), 64'd0);
            end
        end
    end

    // Drive one packet for one edge; if accepted, predict when its pulse appears.
    task automatic issue(input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] rd,
                         input logic [31:0] pc, input bit accept, input logic [31:0] prod,
                         output int edge_cyc);
        exp_t e;
        int   pop_c;
        @(negedge clk);
        issue_in = {1'b1, pc, rd, t1, t2};
        @(posedge clk);
        #1;
        issue_in = '0;
        edge_cyc = cyc;
        if (accept) begin
            pop_c    = (cyc + 1 > last_exp + 1) ? cyc + 1 : last_exp + 1;
            e.dest   = rd;
            e.data   = prod;
            e.pc     = pc;
            e.cyc    = pop_c + ITER;
            last_exp = e.cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int idle_cyc);
        int n = 0;
        @(negedge clk);
        while (mul_busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (mul_busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: mul_busy %0b after %0d cycles, required 0", mul_busy, max_cyc);
        end
        idle_cyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    vec_t        vt [10];
    logic [7:0]  bt1 [3];
    logic [7:0]  bt2 [3];
    logic [31:0] bprod [3];
    int          t0;
    int          tmp;
    int          idle_c;

    initial begin
        vt[0] = '{8'd5,  8'd6,  8'h12, 32'd7,          32'd6,          32'h100, 32'd42};
        vt[1] = '{8'd7,  8'd8,  8'h20, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h104, 32'h0000_0001};
        vt[2] = '{8'd9,  8'd10, 8'h21, 32'h8000_0000,  32'd2,          32'h108, 32'h0000_0000};
        vt[3] = '{8'd0,  8'd11, 8'h22, 32'h0000_DEAD,  32'd5,          32'h10C, 32'h0000_0000};
        vt[4] = '{8'd12, 8'd0,  8'h23, 32'd3,          32'h0000_BEEF,  32'h110, 32'h0000_0000};
        vt[5] = '{8'd13, 8'd14, 8'h24, 32'h1234_5678,  32'h10,         32'h114, 32'h2345_6780};
        vt[6] = '{8'd15, 8'd16, 8'h25, 32'h0000_FFFF,  32'h0000_FFFF,  32'h118, 32'hFFFE_0001};
        vt[7] = '{8'd17, 8'd18, 8'h26, 32'd3,          32'hFFFF_FFFF,  32'h11C, 32'hFFFF_FFFD};
        vt[8] = '{8'd19, 8'd19, 8'h27, 32'h0001_0000,  32'h0001_0000,  32'h120, 32'h0000_0000};
        vt[9] = '{8'd20, 8'd21, 8'h28, 32'd1,          32'hABCD_EF01,  32'h124, 32'hABCD_EF01};

        foreach (regfile[i]) regfile[i] = 32'd0;
        reset         = 1'b1;
        exception_sig = 1'b0;
        mret_sig      = 1'b0;
        issue_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",     64'(mul_busy),         64'd0);
        check("reset_valid",    64'(MUL_result_valid), 64'd0);
        check("reset_overflow", 64'(q_overflow),       64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single multiplies from the table, each into an idle unit.
        for (int i = 0; i < 10; i++) begin
            regfile[vt[i].t1] = vt[i].a;
            regfile[vt[i].t2] = vt[i].b;
            issue(vt[i].t1, vt[i].t2, vt[i].rd, vt[i].pc, 1'b1, vt[i].prod, tmp);
            $display("issue vec %0d tags %0d,%0d rd 0x%0h edge %0d", i, vt[i].t1, vt[i].t2, vt[i].rd, tmp);
            wait_idle(100, idle_c);
            check("table_drained", 64'(sb.size()), 64'd0);
        end

        // Back-to-back: three consecutive issues.
        for (int k = 0; k < 3; k++) begin
            bt1[k] = 8'(40 + 2 * k);
            bt2[k] = 8'(41 + 2 * k);
            regfile[bt1[k]] = $urandom;
            regfile[bt2[k]] = $urandom;
            bprod[k] = regfile[bt1[k]] * regfile[bt2[k]];
        end
        for (int k = 0; k < 3; k++) begin
            issue(bt1[k], bt2[k], 8'(8'h30 + k), 32'(32'h200 + 4 * k), 1'b1, bprod[k], tmp);
            $display("issue b2b %0d edge %0d", k, tmp);
        end
        wait_idle(300, idle_c);
        check("b2b_busy_drop_cycle", 64'(idle_c), 64'(last_pulse + 1));
        check("b2b_drained", 64'(sb.size()), 64'd0);

        // Full queue: a push on the same edge as a pop is accepted.
        regfile[50] = 32'd11;
        regfile[51] = 32'd13;
        for (int k = 0; k < 5; k++) begin
            issue(8'd50, 8'd51, 8'(8'h40 + k), 32'(32'h300 + 4 * k), 1'b1, 32'd143, tmp);
            if (k == 0) t0 = tmp;
            $display("issue fill %0d edge %0d", k, tmp);
        end
        while (cyc < t0 + ITER + 1) begin
            @(posedge clk);
            #1;
        end
        issue(8'd50, 8'd51, 8'h45, 32'h314, 1'b1, 32'd143, tmp);
        $display("issue push-with-pop edge %0d", tmp);
        check("pushpop_no_overflow", 64'(q_overflow), 64'd0);
        wait_idle(400, idle_c);
        check("pushpop_drained", 64'(sb.size()), 64'd0);
        check("pushpop_overflow_end", 64'(q_overflow), 64'd0);

        // Overflow: six consecutive issues, the sixth is dropped.
        regfile[52] = 32'h0001_0001;
        regfile[53] = 32'd9;
        for (int k = 0; k < 6; k++) begin
            issue(8'd52, 8'd53, 8'(8'h50 + k), 32'(32'h400 + 4 * k), (k < QDEPTH + 1), 32'h0009_0009, tmp);
            $display("issue ovf %0d edge %0d", k, tmp);
        end
        check("overflow_set", 64'(q_overflow), 64'd1);
        wait_idle(400, idle_c);
        check("overflow_drained", 64'(sb.size()), 64'd0);
        check("overflow_sticky", 64'(q_overflow), 64'd1);

        // Exception flush at iteration 10 with two entries queued.
        issue(8'd52, 8'd53, 8'h60, 32'h500, 1'b0, 32'd0, t0);
        issue(8'd52, 8'd53, 8'h61, 32'h504, 1'b0, 32'd0, tmp);
        issue(8'd52, 8'd53, 8'h62, 32'h508, 1'b0, 32'd0, tmp);
        while (cyc < t0 + 10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        exception_sig = 1'b1;
        @(posedge clk);
        #1;
        exception_sig = 1'b0;
        @(negedge clk);
        $display("flush exception edge %0d", cyc);
        check("flush_busy",     64'(mul_busy),   64'd0);
        check("flush_overflow", 64'(q_overflow), 64'd0);
        repeat (60) @(negedge clk);
        check("flush_no_results", 64'(sb.size()), 64'd0);
        regfile[54] = 32'd100;
        regfile[55] = 32'd25;
        issue(8'd54, 8'd55, 8'h63, 32'h50C, 1'b1, 32'd2500, tmp);
        $display("issue after flush edge %0d", tmp);
        wait_idle(100, idle_c);
        check("post_flush_drained", 64'(sb.size()), 64'd0);

        // mret on the same edge as an issue: the flush wins.
        @(negedge clk);
        issue_in = {1'b1, 32'h600, 8'h70, 8'd54, 8'd55};
        mret_sig = 1'b1;
        @(posedge clk);
        #1;
        issue_in = '0;
        mret_sig = 1'b0;
        @(negedge clk);
        $display("flush mret with issue edge %0d", cyc);
        check("mret_drops_push", 64'(mul_busy), 64'd0);

        // mret in the middle of a multiply.
        issue(8'd54, 8'd55, 8'h71, 32'h604, 1'b0, 32'd0, tmp);
        repeat (5) @(negedge clk);
        mret_sig = 1'b1;
        @(posedge clk);
        #1;
        mret_sig = 1'b0;
        @(negedge clk);
        $display("flush mret in flight edge %0d", cyc);
        check("mret_flush_busy", 64'(mul_busy), 64'd0);
        repeat (50) @(negedge clk);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_exec.md
MUL_EXEC -- requirements
Module: mul_exec

Interface
REQ-001 Parameter: QDEPTH, 4, issue-queue depth in entries (power of two, >=2).
REQ-002 Parameter: ITER, 32, number of shift-add iterations per multiply.
REQ-003 Port: clk  in  1  single clock; every register updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: exception_sig  in  1  pipeline flush, synchronous, same effect as reset.
REQ-006 Port: mret_sig  in  1  pipeline flush, synchronous, same effect as reset.
REQ-007 Port: issue_in  in  57  issue packet from the multiply reservation station: [56] valid, [55:24] PC, [23:16] Rd tag, [15:8] operand1 tag, [7:0] operand2 tag.
REQ-008 Port: rf_raddr1 / rf_raddr2  out  8 each  physical register read addresses.
REQ-009 Port: rf_rdata1 / rf_rdata2  in  32 each  combinational register-file read data.
REQ-010 Port: MUL_result_valid  out  1  one-cycle result/wakeup pulse.
REQ-011 Port: MUL_result_dest  out  8  destination physical tag.
REQ-012 Port: MUL_result_data  out  32  low 32 bits of the product.
REQ-013 Port: MUL_result_PC  out  32  PC of the completing instruction.
REQ-014 Port: mul_busy  out  1  high when the state is not IDLE or the queue is non-empty.
REQ-015 Port: q_overflow  out  1  sticky flag, set when an issue is dropped.

Function
REQ-016 The block SHALL push issue_in[55:0] into a FIFO of QDEPTH entries on every edge where issue_in[56]=1 and the FIFO is not full.
- If the FIFO is full and no pop occurs that cycle, the packet SHALL be dropped and q_overflow set to 1.
- A push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-018 IDLE -> BUSY SHALL occur when the FIFO is non-empty.
- On that edge the head entry is popped.
- rf_raddr1 and rf_raddr2 SHALL combinationally equal the head's operand tags.
- rf_rdata1 is latched as the multiplicand and rf_rdata2 as the multiplier; PC and Rd are latched.
- The accumulator and the iteration counter are cleared.
REQ-019 An operand tag of 8'd0 SHALL be latched as 32'd0, regardless of rf_rdata.
REQ-020 BUSY SHALL perform one radix-2 shift-add step per cycle:
- if multiplier[0]=1, acc <= acc + multiplicand, modulo 2^32;
- multiplicand <= multiplicand << 1;
- multiplier <= multiplier >> 1.
REQ-021 BUSY -> DONE SHALL occur on the edge that completes iteration ITER.
- The latency is fixed; there is no early termination on zero operands.
REQ-022 DONE SHALL last exactly one cycle.
- MUL_result_valid=1 and MUL_result_dest/data/PC are driven from the latched values.
- If the FIFO is non-empty, DONE -> BUSY and the next head is popped on the same edge, as in REQ-018.
- Otherwise DONE -> IDLE.
REQ-023 Outside DONE, MUL_result_valid, MUL_result_dest, MUL_result_data and MUL_result_PC SHALL all be 0.
REQ-024 Timing for a packet sampled on edge T into an empty FIFO with the FSM in IDLE:
- pop on edge T+1;
- DONE entered on edge T+1+ITER;
- MUL_result_valid high in the cycle after edge T+1+ITER.
REQ-025 The result is the low 32 bits of the product and is therefore sign-agnostic; no high-half or signed variants.
REQ-026 Results SHALL complete in issue order; only one multiply is in flight at a time.

Reset
REQ-027 When reset, exception_sig or mret_sig is high at an edge, the block SHALL:
- empty the FIFO;
- enter IDLE;
- clear the accumulator, counter and latched operands;
- drive all result outputs to 0;
- clear q_overflow.
REQ-028 A flush SHALL take priority over a push, a pop or a state transition in the same cycle.
- An in-flight multiply is discarded and no MUL_result_valid pulse is produced for it.
REQ-029 After reset, mul_busy=0 and the FIFO is empty.

Verification
REQ-030 Single issue: tags 5 and 6 hold 7 and 6, Rd=0x12, PC=0x100 -> exactly one pulse 33 cycles after the issue edge, with data=42, dest=0x12, PC=0x100.
REQ-031 Wrap: both operands 0xFFFFFFFF -> data=0x00000001; 0x80000000 x 2 -> data=0x00000000.
REQ-032 Back-to-back: 3 issues on consecutive cycles -> 3 pulses in issue order.
- Pulses are spaced ITER+1 cycles apart (DONE overlaps the next pop).
- mul_busy stays 1 until the cycle after the last DONE.
REQ-033 Overflow: 6 issues on consecutive cycles while the first is in BUSY -> q_overflow=1 and only the first QDEPTH+1 complete.
REQ-034 Flush: exception_sig pulsed at iteration 10 with 2 entries queued -> no pulses, mul_busy=0, q_overflow=0 on the next cycle.
- A new issue afterwards completes normally.
REQ-035 Zero tag: operand1 tag 0 with rf_rdata1=0xDEAD -> data=0, and latency is unchanged.
